// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  // Binary-encoded controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors and an OR on
// their borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_ab (
    .a    (a),
    .b    (b),
    .diff (d1),
    .bout (b1)
  );

  half_subtractor u_hs_bin (
    .a    (d1),
    .b    (bin),
    .diff (diff),
    .bout (b2)
  );

  // Either stage may generate the borrow; they are mutually exclusive
  always_comb begin
    bout = b1 | b2;
  end

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: a - b with borrow out.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  // Difference is XOR; a borrow is needed only when a=0 and b=1
  always_comb begin
    diff = a ^ b;
    bout = ~a & b;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per clock, LSB first,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic             bit_d;
  logic             bit_bw;

  full_subtractor u_fsub (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .diff (bit_d),
    .bout (bit_bw)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs decoded from the state
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == LAST_BIT) next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: operand load, serial shift, and result capture on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      result     <= '0;
      cnt        <= '0;
      borrow_q   <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            result   <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
          end
        end
        ST_RUN: begin
          borrow_q <= bit_bw;
          result   <= {bit_d, result[WIDTH-1:1]};
          a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff       <= {bit_d, result[WIDTH-1:1]};
            borrow_out <= bit_bw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
